pattern_player: RTL and testbench

- Transmit side of the memory game's serial pattern path: on each round request, appends one pseudo-random bit to the stored game pattern, then plays the whole pattern out serially on an LED strobe.
- The user reproduces the played bits through the input handler, and the stored pattern feeds the comparator.
- Driven by the game FSM: start = gen_pattern, done feeds done_gen_pattern, clr = the FSM's clr.

---
 rtl/pattern_player.sv | 189 ++++++++++++++++++
 tb/tb_pattern_player.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_player.sv
// -----------------------------------------------------------------------------
// pattern_player
//   Transmit side of the memory game's serial pattern path. Each round request
//   appends one pseudo-random bit (from a free-running LFSR) to the stored
//   pattern, then plays the whole pattern out serially, oldest bit first, on an
//   LED strobe: each bit is shown for BIT_CYCLES cycles followed by GAP_CYCLES
//   blank cycles, and a one-cycle done pulse marks the end of playback.
//
//   Optional feature macro: REPLAY_EN
//     When defined, adds a 'replay' input that replays the stored pattern
//     without extending it.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   start         in   round request (level or pulse), sampled only in IDLE
//   clr           in   synchronous clear of pattern and length (wins over start)
//   replay        in   (REPLAY_EN only) replay the stored pattern as-is
//   game_pattern  out  stored pattern, newest bit at [0], unused upper bits 0
//   pattern_len   out  number of valid pattern bits, 0..MAX_LEN
//   led_out       out  bit currently shown, 0 when led_valid is low
//   led_valid     out  high while a bit is being shown
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse when playback completes
//   full          out  pattern_len == MAX_LEN
// -----------------------------------------------------------------------------
module pattern_player #(
  parameter int          MAX_LEN    = 16,
  parameter int          BIT_CYCLES = 4,
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
`ifdef REPLAY_EN
  input  logic        replay,
`endif
  output logic [15:0] game_pattern,
  output logic [4:0]  pattern_len,
  output logic        led_out,
  output logic        led_valid,
  output logic        busy,
  output logic        done,
  output logic        full
);

  // Phase counter holds at most max(BIT_CYCLES, GAP_CYCLES) - 1.
  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [15:0]   pattern_reg, pattern_next;
  logic [4:0]    len_reg, len_next;
  logic [3:0]    idx_reg, idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [15:0]   len_mask;
  logic [4:0]    ext_len;
  logic [4:0]    ext_last;
  logic [4:0]    cur_last;
  logic          is_full;
  logic          replay_req;

  // Keeps bits above MAX_LEN cleared when the pattern shifts left.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
      assign len_mask[gi] = (gi < MAX_LEN);
    end
  endgenerate

`ifdef REPLAY_EN
  assign replay_req = replay && (len_reg != 5'd0);
`else
  assign replay_req = 1'b0;
`endif

  assign is_full  = (len_reg == 5'(MAX_LEN));
  // Length after the EXTEND step; a full pattern is replayed unchanged.
  assign ext_len  = is_full ? len_reg : (len_reg + 5'd1);
  assign ext_last = ext_len - 5'd1;
  assign cur_last = len_reg - 5'd1;

  // Galois LFSR, right shift, taps 16'hB400. Runs every cycle regardless of
  // state or clr so the drawn bit depends on when the player asks for it.
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      lfsr_reg    <= LFSR_SEED;
      pattern_reg <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;

    if (clr) begin
      state_next   = S_IDLE;
      pattern_next = '0;
      len_next     = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_EXTEND;
          end else if (replay_req) begin
            state_next = S_SHOW;
            idx_next   = cur_last[3:0];
            cnt_next   = BIT_LOAD;
          end
        end
        S_EXTEND: begin
          if (!is_full) begin
            pattern_next = {pattern_reg[14:0], lfsr_reg[0]} & len_mask;
            len_next     = ext_len;
          end
          idx_next   = ext_last[3:0];
          cnt_next   = BIT_LOAD;
          state_next = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_reg == '0) begin
            state_next = S_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_reg == '0) begin
            if (idx_reg == 4'd0) begin
              state_next = S_DONE;
            end else begin
              idx_next   = idx_reg - 4'd1;
              cnt_next   = BIT_LOAD;
              state_next = S_SHOW;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state so reset drives them low at once.
  assign game_pattern = pattern_reg;
  assign pattern_len  = len_reg;
  assign full         = is_full;
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_DONE);
  assign led_valid    = (state_reg == S_SHOW);
  assign led_out      = (state_reg == S_SHOW) && pattern_reg[idx_reg];

endmodule

// File: tb/tb_pattern_player.sv
module tb_pattern_player;

  localparam int MAX_LEN = 16;
  localparam int BITC    = 4;
  localparam int GAPC    = 2;
  localparam int SLOT    = BITC + GAPC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        replay = 1'b0;
  logic [15:0] game_pattern;
  logic [4:0]  pattern_len;
  logic        led_out, led_valid, busy, done, full;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [15:0] m_pat = '0;
  int          m_len = 0;

  always #5 clk = ~clk;

  pattern_player dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clr         (clr),
`ifdef REPLAY_EN
    .replay      (replay),
`endif
    .game_pattern(game_pattern),
    .pattern_len (pattern_len),
    .led_out     (led_out),
    .led_valid   (led_valid),
    .busy        (busy),
    .done        (done),
    .full        (full)
  );

  // Model LFSR: polynomial step written arithmetically.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x / 2;
    if (x % 2 == 1) y = y ^ 16'hB400;
    return y;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".done"},  done, 0);
    check({tag, ".valid"}, led_valid, 0);
    check({tag, ".led"},   led_out, 0);
  endtask

  task automatic check_store(input string tag);
    check({tag, ".len"},  pattern_len, m_len);
    check({tag, ".pat"},  game_pattern, m_pat);
    check({tag, ".full"}, full, (m_len == MAX_LEN));
  endtask

  // One playback round. use_replay selects replay instead of start.
  // clr_at > 0 asserts clr during that cycle of the round (cycle 1 = after E0).
  task automatic play(input bit use_replay, input int clr_at);
    int s, L, D, poke, k, b, ph;
    bit e_valid, e_led, e_done;
    @(negedge clk);
    if (use_replay) replay = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; replay = 1'b0;
    if (!use_replay && m_len < MAX_LEN) begin
      m_pat = ((m_pat * 2) + {15'd0, m_lfsr[0]}) & 16'hFFFF;
      m_len++;
    end
    L = m_len;
    s = use_replay ? 1 : 2;
    D = s + L * SLOT;
    poke = $urandom_range(1, D);
    for (int c = 1; c <= D; c++) begin
      e_valid = 0; e_led = 0; e_done = 0;
      if (c == D) e_done = 1;
      else if (c >= s) begin
        k = c - s; b = k / SLOT; ph = k % SLOT;
        e_valid = (ph < BITC);
        e_led   = e_valid ? m_pat[L - 1 - b] : 1'b0;
      end
      check("busy", busy, 1);
      check("done", done, e_done);
      check("led_valid", led_valid, e_valid);
      check("led_out", led_out, e_led);
      if (clr_at > 0 && c == clr_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pat = '0; m_len = 0;
        check_idle("clr_abort");
        check_store("clr_abort");
        $display("round aborted by clr at cycle %0d", c);
        return;
      end
      start = (c == poke);   // start while busy must be ignored
      @(negedge clk);
      start = 1'b0;
    end
    check_idle("after_done");
    check_store("after_done");
    $display("round %s len=%0d pattern=%04h done_cycle=%0d",
             use_replay ? "replay" : "start", L, m_pat, D);
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset, then stay idle for 10 cycles
    #1;
    check_idle("in_reset");
    check_store("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
      check("idle.len", pattern_len, 0);
    end
    $display("reset/idle done");

    // Three consecutive rounds
    for (int r = 0; r < 3; r++) begin
      idle_gap();
      play(1'b0, 0);
    end

    // Round 4 with clr during the second shown bit
    idle_gap();
    play(1'b0, 2 + SLOT + 1);

    // start and clr together: nothing starts
    @(negedge clk);
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("start_clr");
      check_store("start_clr");
      @(negedge clk);
    end
    $display("start+clr ignored");

    // Fill to MAX_LEN, then one more round on a full pattern
    for (int r = 0; r < MAX_LEN + 1; r++) begin
      idle_gap();
      play(1'b0, 0);
    end
    check("full_len", pattern_len, 16);
    check("full_flag", full, 1);

`ifdef REPLAY_EN
    // Replay on an empty pattern is ignored
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    m_pat = '0; m_len = 0;
    replay = 1'b1; @(negedge clk); replay = 1'b0;
    check_idle("replay_empty");
    for (int r = 0; r < 3; r++) begin
      idle_gap();
      play(1'b0, 0);
    end
    idle_gap();
    play(1'b1, 0);
`endif

    // Reset in the middle of playback
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_pat = '0; m_len = 0;
    check_idle("mid_reset");
    check_store("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-playback");

    // LFSR reseeded: next rounds must match the model again
    for (int r = 0; r < 2; r++) begin
      idle_gap();
      play(1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
